// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline registers of the MIPS core:
// reset/handler PCs, exception codes and the per-edge update action.
package pipe_stage_reg_pkg;

    localparam logic [31:0] PC_RESET_VAL   = 32'h0000_3000;
    localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;

    // Exception codes carried down the pipe (0 means no exception).
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    typedef enum logic [1:0] {
        ACT_LOAD     = 2'd0,
        ACT_HOLD     = 2'd1,
        ACT_BUBBLE   = 2'd2,
        ACT_REDIRECT = 2'd3
    } stage_act_e;

    // Redirect beats bubble beats hold; a flush wins over a stall because the
    // upstream stall is what drives the downstream flush.
    function automatic stage_act_e select_act(input logic req, input logic flush,
                                              input logic stall);
        if (req)        return ACT_REDIRECT;
        else if (flush) return ACT_BUBBLE;
        else if (stall) return ACT_HOLD;
        else            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stall/bubble performance counters.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Count up on inc, sticking at all-ones rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter state with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (F/D, D/E, E/M, M/W): PC, payload, exception
// code, delay-slot flag and valid bit, with hold, bubble and redirect.
// Define PIPE_PERF_EN to add the stall_cnt/bubble_cnt performance counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned EXC_W      = 5,
    parameter logic [31:0] PC_RESET   = PC_RESET_VAL,
    parameter logic [31:0] HANDLER_PC = EXC_HANDLER_PC,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              req,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic              in_valid,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,
    output logic              out_valid
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    stage_act_e        act;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic              bd_q, bd_d;
    logic              valid_q, valid_d;

    assign act = select_act(req, flush, stall);

    // Next-state selection; a bubble keeps PC and delay-slot flag so a later
    // exception on this slot can still be reported precisely.
    always_comb begin
        pc_d    = pc_q;
        data_d  = data_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        valid_d = valid_q;
        unique case (act)
            ACT_REDIRECT: begin
                pc_d    = HANDLER_PC;
                data_d  = '0;
                exc_d   = EXC_W'(EXC_NONE);
                bd_d    = 1'b0;
                valid_d = 1'b0;
            end
            ACT_BUBBLE: begin
                pc_d    = in_pc;
                data_d  = '0;
                exc_d   = EXC_W'(EXC_NONE);
                bd_d    = in_bd;
                valid_d = 1'b0;
            end
            ACT_HOLD: begin
            end
            ACT_LOAD: begin
                pc_d    = in_pc;
                data_d  = in_data;
                exc_d   = in_exc;
                bd_d    = in_bd;
                valid_d = in_valid;
            end
            default: begin
            end
        endcase
    end

    // Stage contents, asynchronously reset to an invalid slot at PC_RESET.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            data_q  <= '0;
            exc_q   <= EXC_W'(EXC_NONE);
            bd_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
            valid_q <= valid_d;
        end
    end

    assign out_pc    = pc_q;
    assign out_data  = data_q;
    assign out_exc   = exc_q;
    assign out_bd    = bd_q;
    assign out_valid = valid_q;

`ifdef PIPE_PERF_EN
    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (act == ACT_HOLD),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (act == ACT_BUBBLE),
        .count (bubble_cnt)
    );
`else
    if (CNT_W == 0) begin : g_no_perf
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: vector table plus reset/saturation sequences.
module tb_pipe_stage_reg;

    localparam int unsigned CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, req = 1'b0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_data = 32'h0;
    logic [4:0]  in_exc = 5'h0;
    logic        in_bd = 1'b0, in_valid = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_data;
    logic [4:0]  out_exc;
    logic        out_bd, out_valid;
`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    pipe_stage_reg #(.DATA_W(32), .EXC_W(5), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .req       (req),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .in_valid  (in_valid),
        .out_pc    (out_pc),
        .out_data  (out_data),
        .out_exc   (out_exc),
        .out_bd    (out_bd),
        .out_valid (out_valid)
`ifdef PIPE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, req;
        logic [31:0] pc, data;
        logic [4:0]  exc;
        logic        bd, valid;
        logic [31:0] e_pc, e_data;
        logic [4:0]  e_exc;
        logic        e_bd, e_valid;
        int          e_scnt, e_bcnt;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] pc, input logic [31:0] data,
                              input logic [4:0] exc, input logic bd, input logic valid);
        check({tag, ".pc"}, out_pc, pc);
        check({tag, ".data"}, out_data, data);
        check({tag, ".exc"}, {27'h0, out_exc}, {27'h0, exc});
        check({tag, ".bd"}, {31'h0, out_bd}, {31'h0, bd});
        check({tag, ".valid"}, {31'h0, out_valid}, {31'h0, valid});
    endtask

    task automatic check_cnts(input string tag, input int s, input int b);
`ifdef PIPE_PERF_EN
        check({tag, ".stall_cnt"}, {28'h0, stall_cnt}, 32'(s));
        check({tag, ".bubble_cnt"}, {28'h0, bubble_cnt}, 32'(b));
`else
        if (s < 0 || b < 0) $display("negative count %0d %0d", s, b);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic s, input logic f, input logic r, input logic [31:0] pc,
                          input logic [31:0] d, input logic [4:0] e, input logic bd, input logic v);
        stall = s; flush = f; req = r;
        in_pc = pc; in_data = d; in_exc = e; in_bd = bd; in_valid = v;
    endtask

    initial begin
        //           st fl rq  pc            data          exc   bd v    exp_pc        exp_data      exc   bd v  scnt bcnt
        vecs[0]  = '{0, 0, 0, 32'h3004, 32'h24010001, 5'd0, 0, 1, 32'h3004, 32'h24010001, 5'd0, 0, 1, 0, 0};
        vecs[1]  = '{1, 0, 0, 32'h3008, 32'h11111111, 5'd0, 1, 1, 32'h3004, 32'h24010001, 5'd0, 0, 1, 1, 0};
        vecs[2]  = '{1, 0, 0, 32'h300c, 32'h22222222, 5'd5, 0, 1, 32'h3004, 32'h24010001, 5'd0, 0, 1, 2, 0};
        vecs[3]  = '{1, 0, 0, 32'h300c, 32'h22222222, 5'd5, 0, 0, 32'h3004, 32'h24010001, 5'd0, 0, 1, 3, 0};
        vecs[4]  = '{1, 1, 0, 32'h3010, 32'h33333333, 5'd7, 1, 1, 32'h3010, 32'h0,        5'd0, 1, 0, 3, 1};
        vecs[5]  = '{0, 0, 0, 32'h3014, 32'h8c220000, 5'd4, 0, 1, 32'h3014, 32'h8c220000, 5'd4, 0, 1, 3, 1};
        vecs[6]  = '{0, 1, 0, 32'h3018, 32'haaaa5555, 5'd9, 0, 1, 32'h3018, 32'h0,        5'd0, 0, 0, 3, 2};
        vecs[7]  = '{1, 1, 1, 32'h301c, 32'hbbbb0000, 5'd4, 1, 1, 32'h4180, 32'h0,        5'd0, 0, 0, 3, 2};
        vecs[8]  = '{0, 0, 1, 32'h3020, 32'hcccc0000, 5'd0, 1, 1, 32'h4180, 32'h0,        5'd0, 0, 0, 3, 2};
        vecs[9]  = '{0, 0, 0, 32'h4184, 32'h0,        5'd0, 1, 0, 32'h4184, 32'h0,        5'd0, 1, 0, 3, 2};
        vecs[10] = '{0, 0, 0, 32'h4188, 32'hdeadbeef, 5'd12, 1, 1, 32'h4188, 32'hdeadbeef, 5'd12, 1, 1, 3, 2};

        // Reset asserted between edges, then held across edges with live inputs.
        #1 reset = 1'b1;
        #1;
        check_outs("rst_async", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
        check_cnts("rst_async", 0, 0);
        set_in(0, 0, 0, 32'h3004, 32'h24010001, 5'd0, 1'b0, 1'b1);
        tick();
        tick();
        check_outs("rst_held", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            set_in(vecs[i].stall, vecs[i].flush, vecs[i].req, vecs[i].pc, vecs[i].data,
                   vecs[i].exc, vecs[i].bd, vecs[i].valid);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_data, vecs[i].e_exc,
                       vecs[i].e_bd, vecs[i].e_valid);
            check_cnts($sformatf("vec%0d", i), vecs[i].e_scnt, vecs[i].e_bcnt);
        end

        // Reset arriving mid-stall clears outputs and counters without an edge.
        set_in(1, 0, 0, 32'h5000, 32'h12345678, 5'd3, 1'b0, 1'b1);
        tick();
        check_outs("midstall_hold", 32'h4188, 32'hdeadbeef, 5'd12, 1'b1, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_outs("midstall_rst", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
        check_cnts("midstall_rst", 0, 0);
        tick();
        reset = 1'b0;
        set_in(0, 0, 0, 32'h3040, 32'h00000020, 5'd0, 1'b0, 1'b1);
        tick();
        check_outs("post_rst_load", 32'h3040, 32'h00000020, 5'd0, 1'b0, 1'b1);

        // Long stall: counter saturates; reset mid-count clears it.
        set_in(1, 0, 0, 32'h6000, 32'h0badf00d, 5'd4, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        check_cnts("stall7", 7, 0);
        #1 reset = 1'b1;
        #1;
        check_cnts("stall_rst", 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_outs("stall20_hold", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);
        check_cnts("stall20_sat", 15, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish by 50000");
        $fatal(1, "timeout");
    end

endmodule
